ferryman_solver: RTL and testbench

//  - Solves the ferryman river-crossing puzzle (man, goat, wolf, cabbage) by depth-first search

---
 rtl/ferryman_solver.sv | 190 +++++++++++++++++++
 tb/tb_ferryman_solver.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ferryman_solver.sv
// Depth-first solver for the man/goat/wolf/cabbage crossing; replays the found path as a move stream.
// Optional search-cycle counter output is enabled with FERRYMAN_SOLVER_CYCLES_EN.
module ferryman_solver #(
    parameter int STACK_DEPTH = 16
`ifdef FERRYMAN_SOLVER_CYCLES_EN
    , parameter int CNT_W = 8
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic [3:0] start_state_i,
    output logic       busy_o,
    output logic       mv_valid_o,
    input  logic       mv_ready_i,
    output logic       mv_c_o,
    output logic       mv_w_o,
    output logic       mv_g_o,
    output logic       done_o,
    output logic       fail_o,
    output logic [4:0] path_len_o
`ifdef FERRYMAN_SOLVER_CYCLES_EN
    , output logic [CNT_W-1:0] search_cycles_o
`endif
);
    // state  | meaning
    // IDLE   | waiting for start
    // SEARCH | one DFS candidate per cycle on the top-of-stack node
    // EMIT   | replaying recorded moves from stack bottom upward
    // DONE   | solution fully emitted (or start was already the goal)
    // FAIL   | no solution from start_state
    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam logic [3:0] GOAL = 4'b1111;

    typedef enum logic [2:0] {IDLE, SEARCH, EMIT, DONE, FAIL} state_t;

    // bank vector is {m,g,w,c}
    function automatic logic is_safe(input logic [3:0] s);
        return !((s[2] == s[1]) && (s[3] != s[2])) && !((s[2] == s[0]) && (s[3] != s[2]));
    endfunction

    function automatic logic [2:0] move_bits(input logic [2:0] idx);
        case (idx)
            3'd0:    return 3'b001;
            3'd1:    return 3'b010;
            3'd2:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    state_t           state_q;
    logic [3:0]       stk_node_q [STACK_DEPTH];
    logic [2:0]       stk_idx_q  [STACK_DEPTH];
    logic [IDX_W-1:0] top_q;
    logic [IDX_W-1:0] rd_ptr_q;
    logic [15:0]      visited_q;
    logic             busy_q, mv_valid_q, mv_c_q, mv_w_q, mv_g_q, done_q, fail_q;
    logic [4:0]       path_len_q;

    logic [3:0] top_node, cand;
    logic [2:0] top_idx;
    logic       cand_legal, cand_ok;

    always_comb begin
        top_node   = stk_node_q[top_q];
        top_idx    = stk_idx_q[top_q];
        cand_legal = 1'b1;
        cand       = top_node ^ 4'b1000;
        case (top_idx)
            3'd0: begin cand_legal = (top_node[2] == top_node[3]); cand = top_node ^ 4'b1100; end
            3'd1: begin cand_legal = (top_node[1] == top_node[3]); cand = top_node ^ 4'b1010; end
            3'd2: begin cand_legal = (top_node[0] == top_node[3]); cand = top_node ^ 4'b1001; end
            3'd3: cand_legal = 1'b1;
            default: cand_legal = 1'b0;
        endcase
        cand_ok = cand_legal && is_safe(cand) && !visited_q[cand];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            top_q      <= '0;
            rd_ptr_q   <= '0;
            visited_q  <= '0;
            busy_q     <= 1'b0;
            mv_valid_q <= 1'b0;
            {mv_c_q, mv_w_q, mv_g_q} <= 3'b000;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
            path_len_q <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stk_node_q[i] <= '0;
                stk_idx_q[i]  <= '0;
            end
        end else begin
            case (state_q)
                IDLE, DONE, FAIL: begin
                    if (start_i) begin
                        done_q        <= 1'b0;
                        fail_q        <= 1'b0;
                        path_len_q    <= '0;
                        top_q         <= '0;
                        rd_ptr_q      <= '0;
                        stk_node_q[0] <= start_state_i;
                        stk_idx_q[0]  <= '0;
                        visited_q     <= 16'd1 << start_state_i;
                        if (!is_safe(start_state_i)) begin
                            state_q <= FAIL;
                            fail_q  <= 1'b1;
                        end else if (start_state_i == GOAL) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= SEARCH;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                SEARCH: begin
                    if (top_idx == 3'd4) begin
                        if (top_q == '0) begin
                            state_q <= FAIL;
                            fail_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            // backtrack: the parent moves on to its next candidate
                            top_q <= top_q - 1'b1;
                            stk_idx_q[top_q - 1'b1] <= stk_idx_q[top_q - 1'b1] + 3'd1;
                        end
                    end else if (cand_ok) begin
                        top_q                   <= top_q + 1'b1;
                        stk_node_q[top_q + 1'b1] <= cand;
                        stk_idx_q[top_q + 1'b1]  <= '0;
                        visited_q[cand]         <= 1'b1;
                        if (cand == GOAL) begin
                            state_q    <= EMIT;
                            path_len_q <= 5'(top_q) + 5'd1;
                            rd_ptr_q   <= '0;
                            mv_valid_q <= 1'b1;
                            {mv_c_q, mv_w_q, mv_g_q} <= move_bits(stk_idx_q[0]);
                        end
                    end else begin
                        stk_idx_q[top_q] <= top_idx + 3'd1;
                    end
                end
                EMIT: begin
                    if (mv_ready_i) begin
                        if (5'(rd_ptr_q) == path_len_q - 5'd1) begin
                            state_q    <= DONE;
                            mv_valid_q <= 1'b0;
                            {mv_c_q, mv_w_q, mv_g_q} <= 3'b000;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                        end else begin
                            rd_ptr_q <= rd_ptr_q + 1'b1;
                            {mv_c_q, mv_w_q, mv_g_q} <= move_bits(stk_idx_q[rd_ptr_q + 1'b1]);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef FERRYMAN_SOLVER_CYCLES_EN
    logic [CNT_W-1:0] cyc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q <= '0;
        end else if (start_i && (state_q == IDLE || state_q == DONE || state_q == FAIL)) begin
            cyc_q <= '0;
        end else if (state_q == SEARCH && cyc_q != '1) begin
            cyc_q <= cyc_q + 1'b1;
        end
    end

    assign search_cycles_o = cyc_q;
`endif

    assign busy_o     = busy_q;
    assign mv_valid_o = mv_valid_q;
    assign mv_c_o     = mv_c_q;
    assign mv_w_o     = mv_w_q;
    assign mv_g_o     = mv_g_q;
    assign done_o     = done_q;
    assign fail_o     = fail_q;
    assign path_len_o = path_len_q;

endmodule

// File: tb/tb_ferryman_solver.sv
// Directed bench for ferryman_solver: known 7-move solution, backpressure, unsolvable, goal start, reset mid-emit.
module tb_ferryman_solver;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] start_state = 4'b0000;
    logic       mv_ready = 1'b0;
    logic       busy, mv_valid, mv_c, mv_w, mv_g, done, fail;
    logic [4:0] path_len;
`ifdef FERRYMAN_SOLVER_CYCLES_EN
    logic [7:0] search_cycles;
`endif

    int total = 0;
    int bad = 0;

    logic [2:0] exp_seq [7] = '{3'b001, 3'b000, 3'b010, 3'b001, 3'b100, 3'b000, 3'b001};

    logic [2:0] got [16];
    int         n_got;
    bit         hold_err, timed_out, saw_valid, unsafe_seen, illegal_seen;
    logic [4:0] len_in_emit;
    logic [3:0] banks;

    always #5 clk = ~clk;

    ferryman_solver dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .start_state_i(start_state),
        .busy_o(busy), .mv_valid_o(mv_valid), .mv_ready_i(mv_ready),
        .mv_c_o(mv_c), .mv_w_o(mv_w), .mv_g_o(mv_g),
        .done_o(done), .fail_o(fail), .path_len_o(path_len)
`ifdef FERRYMAN_SOLVER_CYCLES_EN
        , .search_cycles_o(search_cycles)
`endif
    );

    // reference ferryman: nobody may be left with the goat unless the man is with it
    function automatic bit bank_safe(input logic [3:0] b);
        logic m, g, w, c;
        {m, g, w, c} = b;
        return !(((g == w) || (g == c)) && (m != g));
    endfunction

    // mode 0: ready always high; mode 1: ready pattern 1,0,0,1 repeating
    task automatic run(input logic [3:0] st, input int mode, input int abort_after);
        logic [2:0] prev_mv, mv;
        bit prev_stall, ready;
        n_got = 0; hold_err = 0; timed_out = 0; saw_valid = 0;
        unsafe_seen = 0; illegal_seen = 0; len_in_emit = '0;
        banks = st; prev_stall = 0; prev_mv = '0;
        @(negedge clk);
        start_state = st;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            mv_ready = ready;
            mv = {mv_c, mv_w, mv_g};
            if (prev_stall && (!mv_valid || mv !== prev_mv)) hold_err = 1;
            if (mv_valid) begin
                if (!saw_valid) len_in_emit = path_len;
                saw_valid = 1;
                if (ready) begin
                    if (n_got < 16) got[n_got] = mv;
                    n_got++;
                    case (mv)
                        3'b001: begin if (banks[2] != banks[3]) illegal_seen = 1; banks ^= 4'b1100; end
                        3'b010: begin if (banks[1] != banks[3]) illegal_seen = 1; banks ^= 4'b1010; end
                        3'b100: begin if (banks[0] != banks[3]) illegal_seen = 1; banks ^= 4'b1001; end
                        3'b000: banks ^= 4'b1000;
                        default: illegal_seen = 1;
                    endcase
                    if (!bank_safe(banks)) unsafe_seen = 1;
                end
            end
            prev_stall = mv_valid && !ready;
            prev_mv = mv;
            if (abort_after > 0 && n_got == abort_after) return;
            if (done || fail) break;
            @(negedge clk);
        end
        if (!(done || fail)) timed_out = 1;
        mv_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (mv_valid !== 1'b0) begin bad++; $display("FAIL reset_mv_valid got=%b want=0", mv_valid); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (fail !== 1'b0) begin bad++; $display("FAIL reset_fail got=%b want=0", fail); end
        total++; if (path_len !== 5'd0) begin bad++; $display("FAIL reset_path_len got=%0d want=0", path_len); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_solve;
        run(4'b0000, 0, 0);
        total++; if (timed_out) begin bad++; $display("FAIL solve_timeout got=timeout want=done"); end
        total++; if (n_got != 7) begin bad++; $display("FAIL solve_count got=%0d want=7", n_got); end
        for (int i = 0; i < 7; i++) begin
            total++;
            if (got[i] !== exp_seq[i]) begin bad++; $display("FAIL solve_move%0d got=%b want=%b", i, got[i], exp_seq[i]); end
        end
        total++; if (len_in_emit !== 5'd7) begin bad++; $display("FAIL solve_path_len_emit got=%0d want=7", len_in_emit); end
        total++; if (path_len !== 5'd7) begin bad++; $display("FAIL solve_path_len_done got=%0d want=7", path_len); end
        total++; if (done !== 1'b1 || fail !== 1'b0) begin bad++; $display("FAIL solve_flags got=done%b/fail%b want=done1/fail0", done, fail); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL solve_busy got=%b want=0", busy); end
        total++; if (banks !== 4'b1111) begin bad++; $display("FAIL model_banks got=%b want=1111", banks); end
        total++; if (unsafe_seen || illegal_seen) begin bad++; $display("FAIL model_safety got=unsafe%0d/illegal%0d want=0/0", unsafe_seen, illegal_seen); end
`ifdef FERRYMAN_SOLVER_CYCLES_EN
        total++; if (search_cycles == 8'd0) begin bad++; $display("FAIL search_cycles got=%0d want=nonzero", search_cycles); end
`endif
    endtask

    task automatic test_backpressure;
        run(4'b0000, 1, 0);
        total++; if (timed_out) begin bad++; $display("FAIL bp_timeout got=timeout want=done"); end
        total++; if (hold_err) begin bad++; $display("FAIL bp_hold got=changed want=held"); end
        total++; if (n_got != 7) begin bad++; $display("FAIL bp_count got=%0d want=7", n_got); end
        for (int i = 0; i < 7; i++) begin
            total++;
            if (got[i] !== exp_seq[i]) begin bad++; $display("FAIL bp_move%0d got=%b want=%b", i, got[i], exp_seq[i]); end
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL bp_done got=%b want=1", done); end
    endtask

    task automatic test_unsolvable;
        run(4'b0101, 0, 0);
        total++; if (timed_out) begin bad++; $display("FAIL unsafe_timeout got=timeout want=fail"); end
        total++; if (fail !== 1'b1) begin bad++; $display("FAIL unsafe_fail got=%b want=1", fail); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL unsafe_done got=%b want=0", done); end
        total++; if (saw_valid) begin bad++; $display("FAIL unsafe_mv_valid got=1 want=0"); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL unsafe_busy got=%b want=0", busy); end
    endtask

    task automatic test_goal_start;
        run(4'b1111, 0, 0);
        total++; if (timed_out) begin bad++; $display("FAIL goal_timeout got=timeout want=done"); end
        total++; if (done !== 1'b1 || fail !== 1'b0) begin bad++; $display("FAIL goal_flags got=done%b/fail%b want=done1/fail0", done, fail); end
        total++; if (path_len !== 5'd0) begin bad++; $display("FAIL goal_path_len got=%0d want=0", path_len); end
        total++; if (saw_valid) begin bad++; $display("FAIL goal_mv_valid got=1 want=0"); end
    endtask

    task automatic test_reset_mid_emit;
        run(4'b0000, 0, 3);
        @(negedge clk);
        mv_ready = 1'b0;
        total++; if (n_got != 3 || timed_out) begin bad++; $display("FAIL abort_accepts got=%0d want=3", n_got); end
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || mv_valid !== 1'b0) begin bad++; $display("FAIL abort_reset got=busy%b/valid%b want=0/0", busy, mv_valid); end
        total++; if (path_len !== 5'd0 || done !== 1'b0) begin bad++; $display("FAIL abort_reset_len got=len%0d/done%b want=0/0", path_len, done); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(4'b0000, 0, 0);
        total++; if (n_got != 7 || timed_out) begin bad++; $display("FAIL rerun_count got=%0d want=7", n_got); end
        for (int i = 0; i < 7; i++) begin
            total++;
            if (got[i] !== exp_seq[i]) begin bad++; $display("FAIL rerun_move%0d got=%b want=%b", i, got[i], exp_seq[i]); end
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL rerun_done got=%b want=1", done); end
    endtask

    initial begin
        test_reset();
        test_solve();
        test_backpressure();
        test_unsolvable();
        test_goal_start();
        test_reset_mid_emit();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
